// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// State encoding is fixed so debug taps and checkers can decode it directly.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_bit_alu.sv
// One-bit serial full adder with its carry flip-flop.
// carry_prev holds the carry that fed the most recently processed bit.
module serial_bit_alu (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic init_val,
  input  logic en,
  input  logic a_bit,
  input  logic b_bit,
  output logic sum_bit,
  output logic carry,
  output logic carry_prev
);

  logic w_c_next;

  assign sum_bit  = a_bit ^ b_bit ^ carry;
  assign w_c_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);

  // After the final shift, carry_prev is the carry into the MSB position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry      <= 1'b0;
      carry_prev <= 1'b0;
    end else if (init) begin
      carry      <= init_val;
      carry_prev <= 1'b0;
    end else if (en) begin
      carry      <= w_c_next;
      carry_prev <= carry;
    end
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Sequencer for a bit-serial add/subtract: accepts an operand pair, shifts
// WIDTH cycles LSB first, then holds result/carry/overflow until taken.
//
// Handshakes: a transfer occurs on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid only in DONE, and
// result/carry_out/ovf stay stable while out_valid is high and out_ready low.
module serial_addsub_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ovf,
  output logic             busy,
  output logic [2:0]       dbg_status
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic w_init;
  logic w_en;
  logic w_sum;
  logic w_carry;
  logic w_cin_msb;

  assign w_init = (r_state == IDLE) && in_valid;
  assign w_en   = (r_state == SHIFT);

  serial_bit_alu u_alu (
    .clk        (clk),
    .rst        (rst),
    .init       (w_init),
    .init_val   (op),
    .en         (w_en),
    .a_bit      (r_a[0]),
    .b_bit      (r_b[0]),
    .sum_bit    (w_sum),
    .carry      (w_carry),
    .carry_prev (w_cin_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_op        <= OP_ADD;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction runs as A + ~B + 1; the +1 is the preset carry.
            r_a        <= a_in;
            r_b        <= (op == OP_SUB) ? ~b_in : b_in;
            r_op       <= op;
            r_cnt      <= '0;
            r_state    <= SHIFT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        SHIFT: begin
          r_a   <= {w_sum, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign result     = r_out_valid ? r_a : '0;
  assign carry_out  = r_out_valid & w_carry;
  assign ovf        = r_out_valid & (w_cin_msb ^ w_carry);
  assign dbg_status = {r_op, r_state};

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=4: arithmetic vectors,
// latency, backpressure, mid-operation reset and initiation interval.
module tb_serial_addsub_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out;
  logic         ovf;
  logic         busy;
  logic [2:0]   dbg_status;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out),
    .ovf        (ovf),
    .busy       (busy),
    .dbg_status (dbg_status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, in_ready, 1);
  endtask

  // Issue one operation; scramble inputs while it shifts, optionally hold
  // out_ready low for `hold` cycles in DONE, then confirm return to IDLE.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e_res,
                        input logic e_c, input logic e_v, input int hold);
    int lat = 0;
    wait_ready(tag);
    op = o; a_in = a; b_in = b; in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_inrdy_lo"}, in_ready, 0);
    check({tag, "_state"}, dbg_status[1:0], 2'b01);
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      op       = 1'($urandom_range(0, 1));
      a_in     = W'($urandom_range(0, 15));
      b_in     = W'($urandom_range(0, 15));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, W);
    check({tag, "_res"}, result, e_res);
    check({tag, "_cout"}, carry_out, e_c);
    check({tag, "_ovf"}, ovf, e_v);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = ~in_valid;
        a_in     = W'($urandom_range(0, 15));
        b_in     = W'($urandom_range(0, 15));
        @(negedge clk);
        check({tag, "_hold_res"}, result, e_res);
        check({tag, "_hold_cout"}, carry_out, e_c);
        check({tag, "_hold_ovf"}, ovf, e_v);
        check({tag, "_hold_vld"}, out_valid, 1);
        check({tag, "_hold_inrdy"}, in_ready, 0);
        check({tag, "_hold_busy"}, busy, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_vld_lo"}, out_valid, 0);
    check({tag, "_inrdy_back"}, in_ready, 1);
  endtask

  initial begin
    int acc0;
    int acc1;
    int guard;

    #2 rst = 1'b1;
    #1;
    check("rst_inrdy", in_ready, 1);
    check("rst_vld", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res", result, 0);
    check("rst_cout", carry_out, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_5_3",   1'b0, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b1, 0);
    run_op("add_f_1",   1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 0);
    run_op("sub_5_7",   1'b1, 4'b0101, 4'b0111, 4'b1110, 1'b0, 1'b0, 0);
    run_op("sub_7_5",   1'b1, 4'b0111, 4'b0101, 4'b0010, 1'b1, 1'b0, 0);
    run_op("sub_8_1",   1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1, 0);
    run_op("add_0_0",   1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 0);
    run_op("sub_3_3",   1'b1, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 0);
    run_op("bp_add_6_7", 1'b0, 4'b0110, 4'b0111, 4'b1101, 1'b0, 1'b1, 6);

    // Abort an operation after its second shift edge.
    wait_ready("abort");
    op = 1'b0; a_in = 4'b0110; b_in = 4'b0111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_inrdy", in_ready, 1);
    check("abort_vld", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_res", result, 0);
    check("abort_cout", carry_out, 0);
    check("abort_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_abort", 1'b0, 4'b0011, 4'b0001, 4'b0100, 1'b0, 1'b0, 0);

    // Back-to-back with in_valid held: acceptances must be WIDTH+2 edges apart.
    wait_ready("ii");
    op = 1'b0; a_in = 4'b0001; b_in = 4'b0001; in_valid = 1'b1;
    acc0 = -1;
    acc1 = -1;
    for (int k = 0; k < 30 && acc1 < 0; k++) begin
      if (in_ready && in_valid) begin
        if (acc0 < 0) acc0 = k;
        else acc1 = k;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ii_first", acc0, 0);
    check("ii_interval", acc1 - acc0, W + 2);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ii_vld", out_valid, 1);
    check("ii_res", result, 4'b0010);
    check("ii_cout", carry_out, 0);
    @(negedge clk);
    check("ii_idle", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
